// File: rtl/div_rem_sequencer.sv
// div_rem_sequencer: multi-cycle RV32M DIV/DIVU/REM/REMU unit.
// Restoring shift-subtract division, one quotient bit per cycle, operating on
// magnitudes with sign correction applied in a final FIX cycle. Divide-by-zero
// and signed overflow bypass the iteration and complete in one cycle.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   start        request, sampled only in IDLE
//   is_rem       1 = remainder, 0 = quotient
//   is_unsigned  1 = DIVU/REMU, 0 = DIV/REM
//   op_a, op_b   dividend / divisor
//   stall        core holds PC and inputs while high
//   busy         high in any state other than IDLE
//   done         one-cycle pulse, result valid
//   result       registered quotient or remainder
module div_rem_sequencer #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            is_rem,
    input  logic            is_unsigned,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_t;

    localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [XLEN-1:0]    quo_q, rem_q, dvs_q, result_q;
    logic               neg_q_q, neg_r_q, rem_sel_q;

    // Operand conditioning for the accept cycle
    logic               sign_a, sign_b;
    logic [XLEN-1:0]    abs_a, abs_b;
    logic               div_zero, sgn_ovf;

    assign sign_a   = ~is_unsigned & op_a[XLEN-1];
    assign sign_b   = ~is_unsigned & op_b[XLEN-1];
    assign abs_a    = sign_a ? -op_a : op_a;
    assign abs_b    = sign_b ? -op_b : op_b;
    assign div_zero = (op_b == '0);
    assign sgn_ovf  = ~is_unsigned & (op_a == MinNeg) & (op_b == '1);

    // One restoring step. rem_sh may exceed XLEN bits; when its top bit is set
    // the shifted remainder is certainly >= divisor, otherwise the sign bit of
    // the XLEN+1-bit difference decides.
    logic [XLEN:0]      rem_sh, trial;
    logic               trial_ok;
    logic [XLEN-1:0]    quo_fix, rem_fix;

    assign rem_sh   = {rem_q, quo_q[XLEN-1]};
    assign trial    = rem_sh - {1'b0, dvs_q};
    assign trial_ok = rem_q[XLEN-1] | ~trial[XLEN];
    assign quo_fix  = neg_q_q ? -quo_q : quo_q;
    assign rem_fix  = neg_r_q ? -rem_q : rem_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (div_zero || sgn_ovf) ? StDone : StCalc;
                end
            end
            StCalc: begin
                if (cnt_q == '0) begin
                    state_d = StFix;
                end
            end
            StFix:   state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs; stall is forced low during reset even mid-operation
    always_comb begin
        busy  = (state_q != StIdle);
        done  = (state_q == StDone);
        stall = ~rst & (((state_q == StIdle) & start) |
                        (state_q == StCalc) | (state_q == StFix));
    end

    assign result = result_q;

    // Datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
            rem_sel_q <= 1'b0;
            result_q  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        rem_sel_q <= is_rem;
                        neg_q_q   <= sign_a ^ sign_b;
                        neg_r_q   <= sign_a;
                        quo_q     <= abs_a;
                        dvs_q     <= abs_b;
                        rem_q     <= '0;
                        cnt_q     <= CNT_W'(XLEN - 1);
                        if (div_zero) begin
                            result_q <= is_rem ? op_a : '1;
                        end else if (sgn_ovf) begin
                            result_q <= is_rem ? '0 : MinNeg;
                        end
                    end
                end
                StCalc: begin
                    rem_q <= trial_ok ? trial[XLEN-1:0] : rem_sh[XLEN-1:0];
                    quo_q <= {quo_q[XLEN-2:0], trial_ok};
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                StFix: begin
                    result_q <= rem_sel_q ? rem_fix : quo_fix;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_rem_sequencer.sv
// Directed bench for div_rem_sequencer: vector table for latency/result/stall,
// plus hand-written sequences for held start and mid-operation reset.
module tb_div_rem_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        is_rem;
    logic        is_unsigned;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;

    div_rem_sequencer #(.XLEN(32), .CNT_W(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .is_rem      (is_rem),
        .is_unsigned (is_unsigned),
        .op_a        (op_a),
        .op_b        (op_b),
        .stall       (stall),
        .busy        (busy),
        .done        (done),
        .result      (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        rem;
        logic        uns;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Issues one request in the next cycle and waits (bounded) for done.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic rem,
                          input logic uns, output int lat, output logic [31:0] res,
                          output int stall_err);
        @(posedge clk);
        #1;
        op_a = a; op_b = b; is_rem = rem; is_unsigned = uns; start = 1'b1;
        lat = -1; res = '0; stall_err = 0;
        for (int c = 0; c <= 60; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c;
                res = result;
                if (stall) stall_err++;
                break;
            end
            if (!stall || (c > 0 && !busy)) stall_err++;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        start = 1'b0;
    endtask

    initial begin
        int          lat;
        int          serr;
        logic [31:0] res;
        int          first, second, extra, dcnt;
        logic [31:0] res1, res2;

        vecs[0]  = '{32'd100,       32'd7,         1'b0, 1'b0, 32'd14,        34};
        vecs[1]  = '{32'd100,       32'd7,         1'b1, 1'b0, 32'd2,         34};
        vecs[2]  = '{32'hFFFF_FFF9, 32'd2,         1'b0, 1'b0, 32'hFFFF_FFFD, 34};
        vecs[3]  = '{32'hFFFF_FFF9, 32'd2,         1'b1, 1'b0, 32'hFFFF_FFFF, 34};
        vecs[4]  = '{32'd7,         32'hFFFF_FFFE, 1'b1, 1'b0, 32'd1,         34};
        vecs[5]  = '{32'hFFFF_FFFE, 32'd2,         1'b0, 1'b1, 32'h7FFF_FFFF, 34};
        vecs[6]  = '{32'hFFFF_FFFF, 32'h10,        1'b1, 1'b1, 32'hF,         34};
        vecs[7]  = '{32'hFFFF_FFFF, 32'h10,        1'b0, 1'b0, 32'd0,         34};
        vecs[8]  = '{32'd1234,      32'd0,         1'b0, 1'b0, 32'hFFFF_FFFF, 1};
        vecs[9]  = '{32'd1234,      32'd0,         1'b1, 1'b0, 32'd1234,      1};
        vecs[10] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h8000_0000, 1};
        vecs[11] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'd0,         1};
        vecs[12] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'd0,         34};
        vecs[13] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h8000_0000, 34};
        vecs[14] = '{32'h8000_0000, 32'd2,         1'b0, 1'b0, 32'hC000_0000, 34};
        vecs[15] = '{32'hFFFF_FFF8, 32'd2,         1'b1, 1'b0, 32'd0,         34};
        vecs[16] = '{32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b0, 1'b0, 32'd14,        34};
        vecs[17] = '{32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 1'b0, 32'hFFFF_FFFE, 34};
        vecs[18] = '{32'hFFFF_FFF9, 32'd0,         1'b1, 1'b1, 32'hFFFF_FFF9, 1};
        vecs[19] = '{32'd0,         32'd5,         1'b0, 1'b0, 32'd0,         34};

        rst = 1'b1; start = 1'b0; is_rem = 1'b0; is_unsigned = 1'b0;
        op_a = '0; op_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy",   {31'd0, busy},  32'd0);
        check("reset done",   {31'd0, done},  32'd0);
        check("reset stall",  {31'd0, stall}, 32'd0);
        check("reset result", result,         32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].rem, vecs[i].uns, lat, res, serr);
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d result", i), res, vecs[i].exp);
            check($sformatf("vec%0d stall", i), 32'(serr), 32'd0);
        end

        // Start held high throughout, operands disturbed mid-CALC, then a
        // second request accepted in the IDLE cycle right after DONE.
        @(posedge clk);
        #1;
        op_a = 32'd100; op_b = 32'd7; is_rem = 1'b0; is_unsigned = 1'b0; start = 1'b1;
        first = -1; second = -1; extra = 0; res1 = '0; res2 = '0;
        for (int c = 0; c <= 75; c++) begin
            @(negedge clk);
            if (done) begin
                if (first < 0) begin
                    first = c; res1 = result;
                end else if (second < 0) begin
                    second = c; res2 = result;
                end else begin
                    extra++;
                end
            end
            @(posedge clk);
            #1;
            if (c == 10) begin
                op_a = 32'd5000; op_b = 32'd3; is_rem = 1'b1;
            end
            if (c == 34) begin
                op_a = 32'd1000; op_b = 32'd9; is_rem = 1'b1;
            end
            if (c == 69) start = 1'b0;
        end
        check("hold first done cycle",  32'(first),  32'd34);
        check("hold first result",      res1,        32'd14);
        check("hold second done cycle", 32'(second), 32'd69);
        check("hold second result",     res2,        32'd1);
        check("hold extra dones",       32'(extra),  32'd0);

        // Reset asserted in cycle 10 of a DIV
        @(posedge clk);
        #1;
        op_a = 32'd100; op_b = 32'd7; is_rem = 1'b0; is_unsigned = 1'b0; start = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        check("rst cycle stall", {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post rst busy",   {31'd0, busy},  32'd0);
        check("post rst stall",  {31'd0, stall}, 32'd0);
        check("post rst done",   {31'd0, done},  32'd0);
        check("post rst result", result,         32'd0);
        dcnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done || busy) dcnt++;
        end
        check("post rst no activity", 32'(dcnt), 32'd0);
        run_op(32'd100, 32'd7, 1'b1, 1'b0, lat, res, serr);
        check("after rst latency", 32'(lat), 32'd34);
        check("after rst result",  res,      32'd2);
        check("after rst stall",   32'(serr), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
